trend_event_reporter: RTL and testbench
=======================================

// Module: trend_event_reporter
// PURPOSE
//   Downstream consumer of the weighted-majority trend detector output.
//   Watches the 1-bit trend signal, detects level changes, measures how many
//   samples the previous level was held (dwell), and queues one event per
//   change in a small FWFT FIFO drained over a valid/ready interface (host
//   readout / logger). Loss of events on FIFO overflow is flagged sticky.
// PARAMETERS
//   DW     8  width of dwell counter and evt_dwell; saturates at 2^DW-1
//   DEPTH  4  event FIFO depth; power of 2, >= 2
// PORTS
//   clk        in   1                 clock, all state on rising edge
//   reset      in   1                 asynchronous, active-high reset
//   sample_en  in   1                 qualifies trend_in; state updates only when 1
//   trend_in   in   1                 trend bit from the detector
//   clear_ovf  in   1                 synchronous clear of overflow
//   evt_valid  out  1                 FIFO head holds an event
//   evt_ready  in   1                 consumer accepts head this cycle
//   evt_level  out  1                 new trend level of head event
//   evt_dwell  out  DW                samples the previous level was held
//   evt_sat    out  1                 head dwell saturated (true dwell >= 2^DW-1)
//   fifo_count out  $clog2(DEPTH+1)   events currently queued
//   overflow   out  1                 sticky: an event was dropped
// BEHAVIOUR
//   - Reset (async, any time incl. mid-operation): prev_level=0, dwell_cnt=0,
//     FIFO flushed; evt_valid=0, evt_level=0, evt_dwell=0, evt_sat=0,
//     fifo_count=0, overflow=0. After reset, level 0 is the held level.
//   - sample_en=0: detector state unchanged; FIFO pops still occur.
//   - sample_en=1, trend_in==prev_level: dwell_cnt <= min(dwell_cnt+1, 2^DW-1).
//   - sample_en=1, trend_in!=prev_level: push event {level=trend_in,
//     dwell=dwell_cnt, sat=(dwell_cnt==2^DW-1)}; prev_level<=trend_in;
//     dwell_cnt<=1 (the changing sample counts for the new level).
//   - dwell_cnt never wraps; saturation is sticky until the next change.
//   - FIFO: first-word-fall-through; evt_valid = (count!=0); evt_* show head,
//     evt_* = 0 when empty. Pop when evt_valid && evt_ready.
//   - Latency: change sampled at edge N -> evt_valid=1 after edge N (visible
//     cycle N+1) when FIFO was empty. No combinational path trend_in->evt_*.
//   - evt_ready with evt_valid=0: ignored. evt_* stable while valid && !ready.
//   - Push+pop same cycle: both performed, count unchanged, also when full.
//   - Push when full without pop: event dropped, FIFO unchanged, overflow<=1.
//     prev_level/dwell_cnt still update as if accepted.
//   - clear_ovf: overflow<=0 next edge; if a drop occurs same cycle, set wins.
//   - Pointers wrap modulo DEPTH; fifo_count in 0..DEPTH.
// TESTING
//   1 reset; sample_en=1; trend 0 x5 then 1 -> one event level=1 dwell=5
//     sat=0, evt_valid one cycle after the change edge; count=1.
//   2 DW=8: hold 0 for 300 samples then 1 -> dwell=255 sat=1; next 1->0 after
//     3 samples of 1 -> dwell=3 sat=0.
//   3 evt_ready=0, toggle trend 6 times (DEPTH=4) -> count=4, overflow=1,
//     the 4 queued events are the first 4 in order; clear_ovf -> overflow=0.
//   4 FIFO full, change + evt_ready=1 same cycle -> count stays 4, no
//     overflow, new event appears last.
//   5 sample_en gated: trend toggles while sample_en=0 -> no events, dwell
//     frozen; reset asserted with 3 events queued -> all outputs 0 at once.

Source files
------------

// File: rtl/trend_event_reporter.sv
// Trend change reporter: tracks dwell of the held trend level and queues one
// {level, dwell, sat} event per change in a small first-word-fall-through FIFO.
module trend_event_reporter #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_en,
  input  logic                       trend_in,
  input  logic                       clear_ovf,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic                       evt_level,
  output logic [DW-1:0]              evt_dwell,
  output logic                       evt_sat,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       overflow
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DW-1:0] DMAX  = {DW{1'b1}};
  localparam logic [CW-1:0] FULLC = CW'(DEPTH);
  localparam logic [AW-1:0] LASTP = AW'(DEPTH-1);

  typedef struct packed {
    logic          level;
    logic          sat;
    logic [DW-1:0] dwell;
  } evt_t;

  logic          prev_level;
  logic [DW-1:0] dwell_cnt;
  evt_t          mem [DEPTH];
  evt_t          head, new_evt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          change, full, pop, accept, drop;

  assign change  = sample_en && (trend_in != prev_level);
  assign full    = (count == FULLC);
  assign pop     = (count != '0) && evt_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign accept  = change && (!full || pop);
  assign drop    = change && full && !pop;
  assign new_evt = '{level: trend_in, sat: (dwell_cnt == DMAX), dwell: dwell_cnt};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_level <= 1'b0;
      dwell_cnt  <= '0;
    end else if (sample_en) begin
      if (change) begin
        prev_level <= trend_in;
        dwell_cnt  <= DW'(1);
      end else if (dwell_cnt != DMAX) begin
        dwell_cnt  <= dwell_cnt + DW'(1);
      end
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= new_evt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= (wr_ptr == LASTP) ? '0 : wr_ptr + AW'(1);
      if (pop)    rd_ptr <= (rd_ptr == LASTP) ? '0 : rd_ptr + AW'(1);
      if (accept && !pop)      count <= count + CW'(1);
      else if (pop && !accept) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          overflow <= 1'b0;
    else if (drop)      overflow <= 1'b1;
    else if (clear_ovf) overflow <= 1'b0;
  end

  always_comb begin
    head = '0;
    if (count != '0) head = mem[rd_ptr];
  end

  assign evt_valid  = (count != '0);
  assign evt_level  = head.level;
  assign evt_dwell  = head.dwell;
  assign evt_sat    = head.sat;
  assign fifo_count = count;

endmodule

// File: tb/tb_trend_event_reporter.sv
// Directed bench for trend_event_reporter (DW=8, DEPTH=4).
module tb_trend_event_reporter;
  localparam int DW = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset, sample_en, trend_in, clear_ovf, evt_ready;
  logic          evt_valid, evt_level, evt_sat, overflow;
  logic [DW-1:0] evt_dwell;
  logic [2:0]    fifo_count;
  int            checks = 0;
  int            errors = 0;

  trend_event_reporter #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .trend_in(trend_in),
    .clear_ovf(clear_ovf), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_level(evt_level), .evt_dwell(evt_dwell), .evt_sat(evt_sat),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic v, input logic lvl,
                         input int dw, input logic sat, input int cnt, input logic ovf);
    chk({tag, ".valid"}, 32'(evt_valid), 32'(v));
    chk({tag, ".level"}, 32'(evt_level), 32'(lvl));
    chk({tag, ".dwell"}, 32'(evt_dwell), 32'(dw));
    chk({tag, ".sat"},   32'(evt_sat),   32'(sat));
    chk({tag, ".count"}, 32'(fifo_count), 32'(cnt));
    chk({tag, ".ovf"},   32'(overflow),  32'(ovf));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; sample_en = 1'b0; trend_in = 1'b0; clear_ovf = 1'b0; evt_ready = 1'b0;
    step(1);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sample_en = 1'b0; trend_in = 1'b0; clear_ovf = 1'b0; evt_ready = 1'b0;
    #1;
    chk_all("rst", 0, 0, 0, 0, 0, 0);
    step(1);
    reset = 1'b0;

    // 1: five samples of 0 then a change to 1
    sample_en = 1'b1; trend_in = 1'b0;
    step(5);
    chk_all("t1_pre", 0, 0, 0, 0, 0, 0);
    trend_in = 1'b1;
    step(1);
    chk_all("t1_evt", 1, 1, 5, 0, 1, 0);
    step(1);
    chk_all("t1_hold", 1, 1, 5, 0, 1, 0);

    // 2: saturated dwell, then a short dwell
    do_reset();
    sample_en = 1'b1; trend_in = 1'b0;
    step(300);
    trend_in = 1'b1;
    step(1);
    chk_all("t2_sat", 1, 1, 255, 1, 1, 0);
    step(2);
    trend_in = 1'b0;
    step(1);
    chk_all("t2_q2", 1, 1, 255, 1, 2, 0);
    sample_en = 1'b0; evt_ready = 1'b1;
    step(1);
    chk_all("t2_pop1", 1, 0, 3, 0, 1, 0);
    step(1);
    chk_all("t2_empty", 0, 0, 0, 0, 0, 0);
    step(1);
    chk_all("t2_rdy_idle", 0, 0, 0, 0, 0, 0);

    // 3: six toggles into a 4-deep FIFO with no reader
    do_reset();
    sample_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      trend_in = ~trend_in;
      step(1);
    end
    chk_all("t3_full", 1, 1, 0, 0, 4, 0);
    for (int i = 0; i < 2; i++) begin
      trend_in = ~trend_in;
      step(1);
    end
    chk_all("t3_drop", 1, 1, 0, 0, 4, 1);
    sample_en = 1'b0; clear_ovf = 1'b1;
    step(1);
    clear_ovf = 1'b0;
    chk_all("t3_clr", 1, 1, 0, 0, 4, 0);

    // 4: full FIFO, change and pop in the same cycle
    sample_en = 1'b1; trend_in = 1'b1; evt_ready = 1'b1;
    step(1);
    chk_all("t4_pp", 1, 0, 1, 0, 4, 0);
    sample_en = 1'b0;
    step(1);
    chk_all("t4_e3", 1, 1, 1, 0, 3, 0);
    step(1);
    chk_all("t4_e4", 1, 0, 1, 0, 2, 0);
    step(1);
    chk_all("t4_e7", 1, 1, 1, 0, 1, 0);
    step(1);
    chk_all("t4_empty", 0, 0, 0, 0, 0, 0);
    evt_ready = 1'b0;

    // 5: gated samples leave state alone; held level is 1 with dwell 1
    trend_in = 1'b0; step(1);
    trend_in = 1'b1; step(1);
    trend_in = 1'b0; step(1);
    chk_all("t5_gated", 0, 0, 0, 0, 0, 0);
    sample_en = 1'b1; trend_in = 1'b1;
    step(2);
    trend_in = 1'b0;
    step(1);
    chk_all("t5_frozen", 1, 0, 3, 0, 1, 0);
    trend_in = 1'b1; step(1);
    trend_in = 1'b0; step(1);
    chk_all("t5_three", 1, 0, 3, 0, 3, 0);
    #2;
    reset = 1'b1;
    #1;
    chk_all("t5_async_rst", 0, 0, 0, 0, 0, 0);
    step(1);
    reset = 1'b0;
    sample_en = 1'b0;
    step(1);
    chk_all("t5_post_rst", 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
